// File: rtl/csb_glb_req_arb.sv
// Two-requester CSB arbiter in front of the GLB register slave.
// Port 0 is the host CSB path, port 1 the internal command sequencer.
// Round-robin grant into a registered downstream request slot; a small
// tag FIFO remembers which port owns each response-bearing request so
// responses are steered back to their originator in issue order.
module csb_glb_req_arb #(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_AW    = 2
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        r0_req_pvld,
    output logic        r0_req_prdy,
    input  logic [62:0] r0_req_pd,
    input  logic        r1_req_pvld,
    output logic        r1_req_prdy,
    input  logic [62:0] r1_req_pd,
    output logic        csb2glb_req_pvld,
    input  logic        csb2glb_req_prdy,
    output logic [62:0] csb2glb_req_pd,
    input  logic        glb2csb_resp_valid,
    input  logic [33:0] glb2csb_resp_pd,
    output logic        r0_resp_valid,
    output logic [33:0] r0_resp_pd,
    output logic        r1_resp_valid,
    output logic [33:0] r1_resp_pd,
    output logic        arb_err_unexp_resp
);

    localparam logic [TAG_AW:0] TAG_FULL = (TAG_AW+1)'(TAG_DEPTH);

    // Tag FIFO: one bit per entry holding the owning port id.
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [TAG_AW-1:0]    wr_ptr;
    logic [TAG_AW-1:0]    rd_ptr;
    logic [TAG_AW:0]      count;
    logic                 tag_head;

    logic last_gnt;
    logic r0_need_resp, r1_need_resp;
    logic r0_elig, r1_elig;
    logic out_free, tag_ok;
    logic gnt0, gnt1;
    logic push, pop;

    // Reads and non-posted writes expect a response and need a tag.
    assign r0_need_resp = ~r0_req_pd[54] | r0_req_pd[55];
    assign r1_need_resp = ~r1_req_pd[54] | r1_req_pd[55];

    // A pop frees an entry in the same cycle, so a full FIFO can still accept.
    assign pop      = glb2csb_resp_valid & (count != '0);
    assign tag_ok   = (count < TAG_FULL) | pop;
    assign r0_elig  = r0_req_pvld & (~r0_need_resp | tag_ok);
    assign r1_elig  = r1_req_pvld & (~r1_need_resp | tag_ok);
    assign out_free = ~csb2glb_req_pvld | csb2glb_req_prdy;
    assign tag_head = tag_mem[rd_ptr];

    // Round-robin grant: under contention, favour the port that did not win last.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (out_free) begin
            if (r0_elig && r1_elig) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = r0_elig;
                gnt1 = r1_elig;
            end
        end
    end

    assign r0_req_prdy = gnt0;
    assign r1_req_prdy = gnt1;
    assign push        = (gnt0 & r0_need_resp) | (gnt1 & r1_need_resp);

    // Downstream request slot: load on grant, clear once accepted, hold while stalled.
    always_ff @(posedge nvdla_core_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!nvdla_core_rstn) begin
            csb2glb_req_pvld <= 1'b0;
            csb2glb_req_pd   <= '0;
        end else if (gnt0 || gnt1) begin
            csb2glb_req_pvld <= 1'b1;
            csb2glb_req_pd   <= gnt1 ? r1_req_pd : r0_req_pd;
        end else if (csb2glb_req_prdy) begin
            csb2glb_req_pvld <= 1'b0;
        end
    end

    // Round-robin pointer; reset to 1 so port 0 wins the first contention.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            last_gnt <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_gnt <= gnt1;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally at TAG_DEPTH.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage: written on push only.
    always_ff @(posedge nvdla_core_clk) begin
        // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
        if (push) tag_mem[wr_ptr] <= gnt1;
    end

    // Response steering: one-cycle pulse to the port at the FIFO head.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r0_resp_valid <= 1'b0;
            r1_resp_valid <= 1'b0;
            r0_resp_pd    <= '0;
            r1_resp_pd    <= '0;
        end else begin
            r0_resp_valid <= pop & ~tag_head;
            r1_resp_valid <= pop &  tag_head;
            if (pop && !tag_head) r0_resp_pd <= glb2csb_resp_pd;
            if (pop &&  tag_head) r1_resp_pd <= glb2csb_resp_pd;
        end
    end

    // Sticky error: a response arrived with no outstanding tag.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            arb_err_unexp_resp <= 1'b0;
        end else if (glb2csb_resp_valid && (count == '0)) begin
            arb_err_unexp_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_csb_glb_req_arb.sv
// Directed bench for csb_glb_req_arb: inputs change on the falling edge,
// combinational ready is sampled just after, registered outputs 1 ns after
// the rising edge.
module tb_csb_glb_req_arb;

    logic        nvdla_core_clk;
    logic        nvdla_core_rstn;
    logic        r0_req_pvld;
    logic        r0_req_prdy;
    logic [62:0] r0_req_pd;
    logic        r1_req_pvld;
    logic        r1_req_prdy;
    logic [62:0] r1_req_pd;
    logic        csb2glb_req_pvld;
    logic        csb2glb_req_prdy;
    logic [62:0] csb2glb_req_pd;
    logic        glb2csb_resp_valid;
    logic [33:0] glb2csb_resp_pd;
    logic        r0_resp_valid;
    logic [33:0] r0_resp_pd;
    logic        r1_resp_valid;
    logic [33:0] r1_resp_pd;
    logic        arb_err_unexp_resp;

    int n_checks = 0;
    int n_fail   = 0;

    csb_glb_req_arb #(.TAG_DEPTH(4), .TAG_AW(2)) dut (
        .nvdla_core_clk     (nvdla_core_clk),
        .nvdla_core_rstn    (nvdla_core_rstn),
        .r0_req_pvld        (r0_req_pvld),
        .r0_req_prdy        (r0_req_prdy),
        .r0_req_pd          (r0_req_pd),
        .r1_req_pvld        (r1_req_pvld),
        .r1_req_prdy        (r1_req_prdy),
        .r1_req_pd          (r1_req_pd),
        .csb2glb_req_pvld   (csb2glb_req_pvld),
        .csb2glb_req_prdy   (csb2glb_req_prdy),
        .csb2glb_req_pd     (csb2glb_req_pd),
        .glb2csb_resp_valid (glb2csb_resp_valid),
        .glb2csb_resp_pd    (glb2csb_resp_pd),
        .r0_resp_valid      (r0_resp_valid),
        .r0_resp_pd         (r0_resp_pd),
        .r1_resp_valid      (r1_resp_valid),
        .r1_resp_pd         (r1_resp_pd),
        .arb_err_unexp_resp (arb_err_unexp_resp)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // CSB request packet: addr[21:0], wdat[53:22], write[54], nposted[55].
    function automatic logic [62:0] mk_pd(input logic [21:0] addr, input logic [31:0] data,
                                          input logic wr, input logic np);
        logic [62:0] pd;
        pd        = '0;
        pd[21:0]  = addr;
        pd[53:22] = data;
        pd[54]    = wr;
        pd[55]    = np;
        return pd;
    endfunction

    task automatic idle();
        r0_req_pvld        = 1'b0;
        r1_req_pvld        = 1'b0;
        csb2glb_req_prdy   = 1'b1;
        glb2csb_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge nvdla_core_clk);
        idle();
        nvdla_core_rstn = 1'b0;
        @(posedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic test_reset();
        nvdla_core_rstn = 1'b0;
        idle();
        r0_req_pd       = '0;
        r1_req_pd       = '0;
        glb2csb_resp_pd = '0;
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        if ({csb2glb_req_pvld, r0_resp_valid, r1_resp_valid, arb_err_unexp_resp} !== 4'b0000) begin
            $display("FAIL reset_valids: got %b expected 0000",
                     {csb2glb_req_pvld, r0_resp_valid, r1_resp_valid, arb_err_unexp_resp});
            n_fail++;
        end
        n_checks++;
        if ({csb2glb_req_pd, r0_resp_pd, r1_resp_pd} !== '0) begin
            $display("FAIL reset_pd: got req %h r0 %h r1 %h expected 0", csb2glb_req_pd, r0_resp_pd, r1_resp_pd);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic test_read_r0();
        logic [62:0] pd;
        pd = mk_pd(22'h004, 32'h0, 1'b0, 1'b0);
        @(negedge nvdla_core_clk);
        r0_req_pvld = 1'b1;
        r0_req_pd   = pd;
        #1;
        if ({r1_req_prdy, r0_req_prdy} !== 2'b01) begin
            $display("FAIL read_grant: got %b expected 01", {r1_req_prdy, r0_req_prdy});
            n_fail++;
        end
        n_checks++;
        @(posedge nvdla_core_clk);
        #1;
        if (csb2glb_req_pvld !== 1'b1 || csb2glb_req_pd !== pd) begin
            $display("FAIL read_req_out: got pvld %b pd %h expected 1 %h", csb2glb_req_pvld, csb2glb_req_pd, pd);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        idle();
        @(negedge nvdla_core_clk);
        glb2csb_resp_valid = 1'b1;
        glb2csb_resp_pd    = 34'h0_0000_00AB;
        @(posedge nvdla_core_clk);
        #1;
        if ({r1_resp_valid, r0_resp_valid} !== 2'b01 || r0_resp_pd !== 34'h0_0000_00AB) begin
            $display("FAIL read_resp: got valid %b pd %h expected 01 %h",
                     {r1_resp_valid, r0_resp_valid}, r0_resp_pd, 34'h0_0000_00AB);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        idle();
        @(posedge nvdla_core_clk);
        #1;
        if ({r1_resp_valid, r0_resp_valid, csb2glb_req_pvld} !== 3'b000) begin
            $display("FAIL read_resp_pulse: got %b expected 000", {r1_resp_valid, r0_resp_valid, csb2glb_req_pvld});
            n_fail++;
        end
        n_checks++;
    endtask

    // Both ports contend for six cycles; one response per cycle drains tags in order.
    task automatic test_alternate();
        logic [62:0] pd0, pd1, exp_pd;
        logic [1:0]  exp_gnt, exp_rv;
        pd0 = mk_pd(22'h010, 32'h1111_0000, 1'b1, 1'b1);
        pd1 = mk_pd(22'h020, 32'h2222_0000, 1'b1, 1'b1);
        do_reset();
        for (int e = 0; e < 7; e++) begin
            @(negedge nvdla_core_clk);
            r0_req_pvld        = (e < 6);
            r1_req_pvld        = (e < 6);
            r0_req_pd          = pd0;
            r1_req_pd          = pd1;
            glb2csb_resp_valid = (e >= 1);
            glb2csb_resp_pd    = 34'(e);
            #1;
            exp_gnt = (e % 2 == 0) ? 2'b01 : 2'b10;
            exp_pd  = (e % 2 == 0) ? pd0 : pd1;
            if (e < 6) begin
                if ({r1_req_prdy, r0_req_prdy} !== exp_gnt) begin
                    $display("FAIL alt_grant[%0d]: got %b expected %b", e, {r1_req_prdy, r0_req_prdy}, exp_gnt);
                    n_fail++;
                end
                n_checks++;
            end
            @(posedge nvdla_core_clk);
            #1;
            if (e < 6) begin
                if (csb2glb_req_pd !== exp_pd) begin
                    $display("FAIL alt_req_pd[%0d]: got %h expected %h", e, csb2glb_req_pd, exp_pd);
                    n_fail++;
                end
                n_checks++;
            end
            if (e >= 1) begin
                exp_rv = ((e - 1) % 2 == 0) ? 2'b01 : 2'b10;
                if ({r1_resp_valid, r0_resp_valid} !== exp_rv ||
                    (exp_rv[0] ? r0_resp_pd : r1_resp_pd) !== 34'(e)) begin
                    $display("FAIL alt_resp[%0d]: got valid %b r0 %h r1 %h expected %b pd %h",
                             e, {r1_resp_valid, r0_resp_valid}, r0_resp_pd, r1_resp_pd, exp_rv, 34'(e));
                    n_fail++;
                end
                n_checks++;
            end
        end
        @(negedge nvdla_core_clk);
        idle();
    endtask

    task automatic test_tag_full();
        logic [62:0] rd5, pw;
        rd5 = mk_pd(22'h104, 32'h0, 1'b0, 1'b0);
        pw  = mk_pd(22'h200, 32'hCAFE_0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge nvdla_core_clk);
            r1_req_pvld = 1'b1;
            r1_req_pd   = mk_pd(22'(256 + i), 32'h0, 1'b0, 1'b0);
            #1;
            if (r1_req_prdy !== 1'b1) begin
                $display("FAIL full_fill[%0d]: got prdy %b expected 1", i, r1_req_prdy);
                n_fail++;
            end
            n_checks++;
            @(posedge nvdla_core_clk);
        end
        @(negedge nvdla_core_clk);
        r1_req_pd   = rd5;
        r0_req_pvld = 1'b1;
        r0_req_pd   = pw;
        #1;
        if ({r1_req_prdy, r0_req_prdy} !== 2'b01) begin
            $display("FAIL full_stall_posted: got %b expected 01", {r1_req_prdy, r0_req_prdy});
            n_fail++;
        end
        n_checks++;
        @(posedge nvdla_core_clk);
        #1;
        if (csb2glb_req_pd !== pw) begin
            $display("FAIL full_posted_pd: got %h expected %h", csb2glb_req_pd, pw);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        r0_req_pvld = 1'b0;
        #1;
        if (r1_req_prdy !== 1'b0) begin
            $display("FAIL full_still_stalled: got %b expected 0", r1_req_prdy);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        glb2csb_resp_valid = 1'b1;
        glb2csb_resp_pd    = 34'h3_0000_0001;
        #1;
        if (r1_req_prdy !== 1'b1) begin
            $display("FAIL full_pop_grant: got %b expected 1", r1_req_prdy);
            n_fail++;
        end
        n_checks++;
        @(posedge nvdla_core_clk);
        #1;
        if ({r1_resp_valid, r0_resp_valid} !== 2'b10 || r1_resp_pd !== 34'h3_0000_0001 || csb2glb_req_pd !== rd5) begin
            $display("FAIL full_pop_push: got valid %b pd %h req %h expected 10 %h %h",
                     {r1_resp_valid, r0_resp_valid}, r1_resp_pd, csb2glb_req_pd, 34'h3_0000_0001, rd5);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            @(negedge nvdla_core_clk);
            r1_req_pvld        = 1'b0;
            glb2csb_resp_valid = 1'b1;
            glb2csb_resp_pd    = 34'(i + 2);
            @(posedge nvdla_core_clk);
            #1;
            if ({r1_resp_valid, r0_resp_valid} !== 2'b10 || r1_resp_pd !== 34'(i + 2)) begin
                $display("FAIL full_drain[%0d]: got valid %b pd %h expected 10 %h",
                         i, {r1_resp_valid, r0_resp_valid}, r1_resp_pd, 34'(i + 2));
                n_fail++;
            end
            n_checks++;
        end
        @(negedge nvdla_core_clk);
        idle();
    endtask

    task automatic test_backpressure();
        logic [62:0] pa, pb, pc;
        logic [1:0]  exp_rv;
        pa = mk_pd(22'h0A0, 32'h0, 1'b0, 1'b0);
        pb = mk_pd(22'h0B0, 32'h0, 1'b0, 1'b0);
        pc = mk_pd(22'h0C0, 32'h0, 1'b0, 1'b0);
        @(negedge nvdla_core_clk);
        r0_req_pvld = 1'b1;
        r0_req_pd   = pa;
        @(posedge nvdla_core_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge nvdla_core_clk);
            csb2glb_req_prdy = 1'b0;
            r0_req_pd        = pb;
            r1_req_pvld      = 1'b1;
            r1_req_pd        = pc;
            #1;
            if ({r1_req_prdy, r0_req_prdy} !== 2'b00) begin
                $display("FAIL bp_no_grant[%0d]: got %b expected 00", i, {r1_req_prdy, r0_req_prdy});
                n_fail++;
            end
            n_checks++;
            @(posedge nvdla_core_clk);
            #1;
            if (csb2glb_req_pvld !== 1'b1 || csb2glb_req_pd !== pa) begin
                $display("FAIL bp_hold[%0d]: got pvld %b pd %h expected 1 %h", i, csb2glb_req_pvld, csb2glb_req_pd, pa);
                n_fail++;
            end
            n_checks++;
        end
        @(negedge nvdla_core_clk);
        csb2glb_req_prdy = 1'b1;
        #1;
        if ({r1_req_prdy, r0_req_prdy} !== 2'b10) begin
            $display("FAIL bp_release_grant: got %b expected 10", {r1_req_prdy, r0_req_prdy});
            n_fail++;
        end
        n_checks++;
        @(posedge nvdla_core_clk);
        #1;
        if (csb2glb_req_pd !== pc) begin
            $display("FAIL bp_release_pd: got %h expected %h", csb2glb_req_pd, pc);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        r1_req_pvld = 1'b0;
        @(posedge nvdla_core_clk);
        #1;
        if (csb2glb_req_pd !== pb) begin
            $display("FAIL bp_second_pd: got %h expected %h", csb2glb_req_pd, pb);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            @(negedge nvdla_core_clk);
            r0_req_pvld        = 1'b0;
            glb2csb_resp_valid = 1'b1;
            glb2csb_resp_pd    = 34'(16 + i);
            @(posedge nvdla_core_clk);
            #1;
            exp_rv = (i == 1) ? 2'b10 : 2'b01;
            if ({r1_resp_valid, r0_resp_valid} !== exp_rv) begin
                $display("FAIL bp_resp_order[%0d]: got %b expected %b", i, {r1_resp_valid, r0_resp_valid}, exp_rv);
                n_fail++;
            end
            n_checks++;
        end
        @(negedge nvdla_core_clk);
        idle();
    endtask

    task automatic test_unexp_resp();
        @(negedge nvdla_core_clk);
        glb2csb_resp_valid = 1'b1;
        glb2csb_resp_pd    = 34'h0_0000_0055;
        @(posedge nvdla_core_clk);
        #1;
        if ({r1_resp_valid, r0_resp_valid, arb_err_unexp_resp} !== 3'b001) begin
            $display("FAIL unexp_flag: got %b expected 001", {r1_resp_valid, r0_resp_valid, arb_err_unexp_resp});
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        idle();
        repeat (3) @(posedge nvdla_core_clk);
        #1;
        if (arb_err_unexp_resp !== 1'b1) begin
            $display("FAIL unexp_sticky: got %b expected 1", arb_err_unexp_resp);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b0;
        @(posedge nvdla_core_clk);
        #1;
        if (arb_err_unexp_resp !== 1'b0) begin
            $display("FAIL unexp_clear: got %b expected 0", arb_err_unexp_resp);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [62:0] pw0, pw1;
        pw0 = mk_pd(22'h300, 32'h0000_00A0, 1'b1, 1'b0);
        pw1 = mk_pd(22'h310, 32'h0000_00B1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge nvdla_core_clk);
            r1_req_pvld = 1'b1;
            r1_req_pd   = mk_pd(22'(1024 + i), 32'h0, 1'b0, 1'b0);
            @(posedge nvdla_core_clk);
        end
        @(negedge nvdla_core_clk);
        idle();
        nvdla_core_rstn = 1'b0;
        @(posedge nvdla_core_clk);
        #1;
        if ({csb2glb_req_pvld, r0_resp_valid, r1_resp_valid} !== 3'b000 || csb2glb_req_pd !== '0) begin
            $display("FAIL mid_reset_clear: got valids %b pd %h expected 000 0",
                     {csb2glb_req_pvld, r0_resp_valid, r1_resp_valid}, csb2glb_req_pd);
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        r0_req_pvld     = 1'b1;
        r0_req_pd       = pw0;
        r1_req_pvld     = 1'b1;
        r1_req_pd       = pw1;
        #1;
        if ({r1_req_prdy, r0_req_prdy} !== 2'b01) begin
            $display("FAIL mid_first_grant: got %b expected 01", {r1_req_prdy, r0_req_prdy});
            n_fail++;
        end
        n_checks++;
        @(posedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
        idle();
        @(negedge nvdla_core_clk);
        glb2csb_resp_valid = 1'b1;
        glb2csb_resp_pd    = 34'h0_0000_0077;
        @(posedge nvdla_core_clk);
        #1;
        if ({r1_resp_valid, r0_resp_valid, arb_err_unexp_resp} !== 3'b001) begin
            $display("FAIL mid_tags_discarded: got %b expected 001", {r1_resp_valid, r0_resp_valid, arb_err_unexp_resp});
            n_fail++;
        end
        n_checks++;
        @(negedge nvdla_core_clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_read_r0();
        test_alternate();
        test_tag_full();
        test_backpressure();
        test_unexp_resp();
        test_reset_mid();
        repeat (2) @(posedge nvdla_core_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csb_glb_req_arb.md
Name: csb_glb_req_arb

Overview:
- Two-requester CSB arbiter in front of the GLB register slave (csb2glb request / glb2csb response interface).
- Port 0 is the host CSB path; port 1 is an internal command sequencer that programs GLB mask/status registers without host involvement.
- Round-robin arbitration drives a registered downstream request.
- A tag FIFO records which port owns each response-bearing request, so every response is routed back to its originator in order.

Parameters:
- TAG_DEPTH, 4, maximum outstanding response-bearing requests; must be a power of 2, at least 2.
- TAG_AW, 2, log2(TAG_DEPTH).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  synchronous active-low reset
- r0_req_pvld  in  1  port 0 request valid
- r0_req_prdy  out  1  port 0 request ready
- r0_req_pd  in  63  port 0 request packet (CSB format)
- r1_req_pvld  in  1  port 1 request valid
- r1_req_prdy  out  1  port 1 request ready
- r1_req_pd  in  63  port 1 request packet
- csb2glb_req_pvld  out  1  downstream request valid
- csb2glb_req_prdy  in  1  downstream request ready
- csb2glb_req_pd  out  63  downstream request packet
- glb2csb_resp_valid  in  1  downstream response valid (no backpressure)
- glb2csb_resp_pd  in  34  downstream response packet
- r0_resp_valid  out  1  port 0 response valid
- r0_resp_pd  out  34  port 0 response packet
- r1_resp_valid  out  1  port 1 response valid
- r1_resp_pd  out  34  port 1 response packet
- arb_err_unexp_resp  out  1  sticky flag: response arrived with tag FIFO empty

Behaviour:
- All sequential state uses nvdla_core_clk and is reset synchronously when nvdla_core_rstn=0.
- Reset values:
  - csb2glb_req_pvld, r0/r1_resp_valid, arb_err_unexp_resp = 0.
  - csb2glb_req_pd, r0/r1_resp_pd = 0.
  - Tag FIFO empty (wr_ptr = rd_ptr = 0, count = 0).
  - Round-robin pointer last_gnt = 1, so port 0 wins the first contention.
- Packet decode:
  - write = pd[54], nposted = pd[55].
  - need_resp = ~write | nposted.
  - Posted writes produce no response and take no tag.
- Eligibility: a port is eligible when pvld=1 and (need_resp=0 or tag_ok).
  - tag_ok = (count < TAG_DEPTH) | pop_this_cycle.
- Output slot: out_free = ~csb2glb_req_pvld | csb2glb_req_prdy.
- Grant (combinational):
  - Only when out_free.
  - If both ports are eligible, grant the port != last_gnt.
  - Otherwise grant the single eligible port.
  - At most one grant per cycle.
- Handshake:
  - rX_req_prdy = grant to X.
  - Ports must hold pd stable while pvld=1 and prdy=0.
  - prdy is never asserted for a port that is not eligible.
- On grant:
  - Next cycle csb2glb_req_pvld=1 and csb2glb_req_pd = granted pd (1-cycle request latency).
  - last_gnt = granted port.
  - If need_resp, push the port id into the tag FIFO.
- With no grant and csb2glb_req_prdy=1, csb2glb_req_pvld drops to 0.
- The output register holds its value while csb2glb_req_pvld=1 and csb2glb_req_prdy=0.
- Response routing:
  - On glb2csb_resp_valid=1 with count>0, pop the tag FIFO head.
  - Next cycle, assert r{head}_resp_valid=1 for one cycle, with r{head}_resp_pd = glb2csb_resp_pd (1-cycle response latency).
  - The other port's response valid stays 0.
  - Both resp_pd registers update only on their own valid.
- Unexpected response (glb2csb_resp_valid=1, count=0):
  - Response is dropped; no rX_resp_valid.
  - arb_err_unexp_resp is set and stays set until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, a push is allowed in the same cycle as a pop.
- Pointers wrap modulo TAG_DEPTH.
- count is TAG_AW+1 bits wide and never exceeds TAG_DEPTH.
- Reset mid-operation: pending requests and outstanding tags are discarded. Responses arriving after reset release are treated as unexpected.

Test Plan:
- Read only on r0 (pd[54]=0, addr 0x004) -> csb2glb_req_pvld 1 cycle after handshake; resp pd 0x0_0000_00AB returns on r0_resp_valid 1 cycle after glb2csb_resp_valid; r1_resp_valid stays 0.
- Both ports hold a nonposted write for 6 cycles -> grants alternate r0, r1, r0, r1, r0, r1; six tags pushed in that order; responses route r0, r1, r0... in order.
- Port 1 issues 4 reads with responses withheld (TAG_DEPTH=4) -> 5th read stalls (r1_req_prdy=0). A posted write on r0 still passes. The 5th read is granted in the same cycle the first response pops.
- Downstream prdy held 0 for 3 cycles with pvld=1 -> csb2glb_req_pd stable, no port granted; stall releases on prdy=1.
- glb2csb_resp_valid pulse with FIFO empty -> no rX_resp_valid; arb_err_unexp_resp=1 until nvdla_core_rstn=0, then 0.
- Reset asserted with 2 tags outstanding -> count=0 and all valids 0 on the next edge; first grant after release goes to r0 under contention.
